// File: rtl/player_pkg.sv
// Shared types and constants for the multi-shot player ship controller.
package player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEFT      = 3'd1,
    ST_RIGHT     = 3'd2,
    ST_HIT_PAUSE = 3'd3,
    ST_DEAD      = 3'd4
  } player_state_e;

  localparam int BULLET_W = 6;
  localparam int BULLET_H = 10;

  localparam int LEFT_BORDER  = 9;
  localparam int RIGHT_BORDER = 629;
  localparam int SPAWN_Y      = 424;
  localparam int CEILING      = 10;

endpackage

// File: rtl/player_bullet_slot.sv
// One bullet slot: launches at the muzzle, climbs once per frame, retires at
// the ceiling or on an enemy hit. A launch overrides any retire in the same cycle.
module player_bullet_slot
  import player_pkg::*;
#(
  parameter int spawn_y_p = SPAWN_Y,
  parameter int step_p    = 10
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       launch,
  input  logic [9:0] launch_left,
  input  logic       frame,
  input  logic       hit,
  input  logic       clear,
  input  logic [9:0] ceiling,
  output logic       valid,
  output logic [9:0] left,
  output logic [9:0] top
);

  localparam logic [9:0] SPAWN = 10'(spawn_y_p);
  localparam logic [9:0] STEP  = 10'(step_p);

  logic [9:0] next_top;

  // Saturating climb so a shallow ceiling can never wrap the top coordinate.
  assign next_top = (top > STEP) ? top - STEP : '0;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid <= 1'b0;
      left  <= '0;
      top   <= SPAWN;
    end else if (launch) begin
      valid <= 1'b1;
      left  <= launch_left;
      top   <= SPAWN;
    end else if (clear) begin
      valid <= 1'b0;
      top   <= SPAWN;
    end else if (valid) begin
      if (hit) begin
        valid <= 1'b0;
      end else if (frame) begin
        top <= next_top;
        if (next_top <= ceiling) valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/player_multishot.sv
// Player ship controller with several concurrent bullets and a per-frame fire
// cooldown. Define PLAYER_AUTOFIRE_EN to let a held fire button re-fire.
module player_multishot
  import player_pkg::*;
#(
  parameter logic [11:0] color_p        = {4'h5, 4'hE, 4'h5},
  parameter int          max_bullets_p  = 3,
  parameter int          ship_width_p   = 40,
  parameter int          step_p         = 5,
  parameter int          bullet_step_p  = 10,
  parameter int          left_border_p  = LEFT_BORDER,
  parameter int          right_border_p = RIGHT_BORDER,
  parameter int          spawn_y_p      = SPAWN_Y,
  parameter int          ceiling_p      = CEILING,
  parameter int          lives_reset_p  = 2,
  parameter int          lives_max_p    = 3,
  parameter int          cooldown_p     = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              frame_i,
  input  logic                              move_left_i,
  input  logic                              move_right_i,
  input  logic                              shoot_i,
  input  logic                              hit_i,
  input  logic [max_bullets_p-1:0]          hit_enemy_i,
  input  logic                              add_life_i,
  output logic                              alive_o,
  output logic                              paused_o,
  output logic [$clog2(lives_max_p+1)-1:0]  lives_o,
  output logic [9:0]                        pos_left_o,
  output logic [9:0]                        pos_right_o,
  output logic [3:0]                        red_o,
  output logic [3:0]                        green_o,
  output logic [3:0]                        blue_o,
  output logic [max_bullets_p-1:0]          bullet_valid_o,
  output logic [10*max_bullets_p-1:0]       bullet_left_o,
  output logic [10*max_bullets_p-1:0]       bullet_top_o,
  output logic [2:0]                        state_o
);

  localparam int LW = $clog2(lives_max_p + 1);
  localparam int CW = (cooldown_p < 1) ? 1 : $clog2(cooldown_p + 1);

  localparam logic [9:0]    CENTER      = 10'((left_border_p + right_border_p - ship_width_p) / 2);
  localparam logic [9:0]    L_MIN       = 10'(left_border_p);
  localparam logic [9:0]    L_MAX       = 10'(right_border_p - ship_width_p);
  localparam logic [9:0]    STEP        = 10'(step_p);
  localparam logic [9:0]    MUZZLE      = 10'(ship_width_p / 2 - BULLET_W / 2);
  localparam logic [LW-1:0] LIVES_RESET = LW'(lives_reset_p);
  localparam logic [LW-1:0] LIVES_MAX   = LW'(lives_max_p);
  localparam logic [CW-1:0] COOLDOWN    = CW'(cooldown_p);

  player_state_e            state;
  player_state_e            btn_state;
  logic [9:0]               pos_left;
  logic [9:0]               pos_next;
  logic [LW-1:0]            lives;
  logic [CW-1:0]            cooldown;
  logic                     shoot_q;
  logic                     shoot_rise;
  logic                     active;
  logic                     trigger;
  logic                     fire;
  logic                     taken;
  logic [max_bullets_p-1:0] launch;
  logic [max_bullets_p-1:0] bullet_valid;
  logic [max_bullets_p-1:0] slot_hit;

  assign shoot_rise = shoot_i & ~shoot_q;
  assign active     = (state == ST_IDLE) || (state == ST_LEFT) || (state == ST_RIGHT);

`ifdef PLAYER_AUTOFIRE_EN
  // Armed only by a shot that actually fired from a rising edge; releasing
  // the button or taking a hit disarms it.
  logic armed;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                armed <= 1'b0;
    else if (!shoot_i || !active) armed <= 1'b0;
    else if (hit_i)               armed <= 1'b0;
    else if (fire)                armed <= 1'b1;
  end

  assign trigger = shoot_rise | (shoot_i & armed);
`else
  assign trigger = shoot_rise;
`endif

  assign fire = active & ~hit_i & trigger & (cooldown == '0) & ~(&bullet_valid);

  // NOTE: every combinational output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    btn_state = ST_IDLE;
    if (move_left_i && !move_right_i)      btn_state = ST_LEFT;
    else if (move_right_i && !move_left_i) btn_state = ST_RIGHT;
  end

  always_comb begin
    pos_next = pos_left;
    if (state == ST_LEFT)
      pos_next = (pos_left >= L_MIN + STEP) ? pos_left - STEP : L_MIN;
    else if (state == ST_RIGHT)
      pos_next = (pos_left + STEP <= L_MAX) ? pos_left + STEP : L_MAX;
  end

  // Lowest-index free slot takes the launch.
  always_comb begin
    launch = '0;
    taken  = 1'b0;
    for (int k = 0; k < max_bullets_p; k++) begin
      if (fire && !taken && !bullet_valid[k]) begin
        launch[k] = 1'b1;
        taken     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= ST_IDLE;
      pos_left <= CENTER;
      lives    <= LIVES_RESET;
      cooldown <= '0;
      shoot_q  <= 1'b0;
    end else begin
      shoot_q <= shoot_i;
      case (state)
        ST_IDLE, ST_LEFT, ST_RIGHT: begin
          if (hit_i) begin
            cooldown <= '0;
            if (lives > LW'(1)) begin
              lives <= lives - LW'(1);
              state <= ST_HIT_PAUSE;
            end else begin
              lives <= '0;
              state <= ST_DEAD;
            end
          end else begin
            state <= btn_state;
            if (frame_i) pos_left <= pos_next;
            if (fire)                              cooldown <= COOLDOWN;
            else if (frame_i && cooldown != '0)    cooldown <= cooldown - CW'(1);
            if (add_life_i && lives < LIVES_MAX)   lives <= lives + LW'(1);
          end
        end
        ST_HIT_PAUSE: begin
          if (shoot_rise) begin
            pos_left <= CENTER;
            state    <= btn_state;
          end
          if (add_life_i && lives < LIVES_MAX) lives <= lives + LW'(1);
        end
        ST_DEAD: begin
          if (shoot_rise) begin
            pos_left <= CENTER;
            lives    <= LIVES_RESET;
            state    <= btn_state;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bullets are frozen outside the flying states; a hit clears them all.
  assign slot_hit = hit_enemy_i & {max_bullets_p{active}};

  for (genvar k = 0; k < max_bullets_p; k++) begin : g_slot
    player_bullet_slot #(
      .spawn_y_p (spawn_y_p),
      .step_p    (bullet_step_p)
    ) u_slot (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .launch      (launch[k]),
      .launch_left (pos_left + MUZZLE),
      .frame       (frame_i & active),
      .hit         (slot_hit[k]),
      .clear       (active & hit_i),
      .ceiling     (10'(ceiling_p)),
      .valid       (bullet_valid[k]),
      .left        (bullet_left_o[10*k +: 10]),
      .top         (bullet_top_o[10*k +: 10])
    );
  end

  assign bullet_valid_o = bullet_valid;
  assign state_o        = state;
  assign alive_o        = (state != ST_DEAD);
  assign paused_o       = (state == ST_HIT_PAUSE);
  assign lives_o        = lives;
  assign pos_left_o     = pos_left;
  assign pos_right_o    = pos_left + 10'(ship_width_p);
  assign red_o          = color_p[11:8];
  assign green_o        = color_p[7:4];
  assign blue_o         = color_p[3:0];

endmodule

// File: tb/tb_player_multishot.sv
// Scoreboard bench for player_multishot: a behavioural ship model predicts every
// cycle's outputs; a separate monitor compares them against the DUT.
module tb_player_multishot;
  import player_pkg::*;

  localparam int NB     = 3;
  localparam int CENTER = (9 + 629 - 40) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame = 1'b0, left = 1'b0, right = 1'b0, shoot = 1'b0, hit = 1'b0, add_life = 1'b0;
  logic [NB-1:0] hit_enemy = '0;

  logic          alive, paused;
  logic [1:0]    lives;
  logic [9:0]    pos_left, pos_right;
  logic [3:0]    red, green, blue;
  logic [NB-1:0] bvalid;
  logic [10*NB-1:0] bleft, btop;
  logic [2:0]    state;

  player_multishot dut (
    .clk_i(clk), .reset_ni(rst_n), .frame_i(frame), .move_left_i(left),
    .move_right_i(right), .shoot_i(shoot), .hit_i(hit), .hit_enemy_i(hit_enemy),
    .add_life_i(add_life), .alive_o(alive), .paused_o(paused), .lives_o(lives),
    .pos_left_o(pos_left), .pos_right_o(pos_right), .red_o(red), .green_o(green),
    .blue_o(blue), .bullet_valid_o(bvalid), .bullet_left_o(bleft),
    .bullet_top_o(btop), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  player_state_e m_st;
  int m_pos, m_lives, m_cd;
  bit m_prev;
  bit m_bv[NB];
  int m_bl[NB], m_bt[NB];

  task automatic model_reset();
    m_st = ST_IDLE; m_pos = CENTER; m_lives = 2; m_cd = 0; m_prev = 0;
    for (int k = 0; k < NB; k++) begin m_bv[k] = 0; m_bl[k] = 0; m_bt[k] = 424; end
  endtask

  task automatic model_step();
    player_state_e btn, old_st;
    int old_pos, free_k;
    bit rise;
    bit old_bv[NB];
    if (!rst_n) begin
      model_reset();
      return;
    end
    btn     = (left && !right) ? ST_LEFT : (right && !left) ? ST_RIGHT : ST_IDLE;
    old_st  = m_st;
    old_pos = m_pos;
    rise    = shoot && !m_prev;
    old_bv  = m_bv;
    if (old_st inside {ST_IDLE, ST_LEFT, ST_RIGHT}) begin
      if (hit) begin
        if (m_lives > 1) begin m_lives--; m_st = ST_HIT_PAUSE; end
        else begin m_lives = 0; m_st = ST_DEAD; end
        for (int k = 0; k < NB; k++) m_bv[k] = 0;
        m_cd = 0;
      end else begin
        m_st = btn;
        if (frame && old_st == ST_LEFT)  m_pos = (old_pos - 5 < 9) ? 9 : old_pos - 5;
        if (frame && old_st == ST_RIGHT) m_pos = (old_pos + 45 > 629) ? 629 - 40 : old_pos + 5;
        for (int k = 0; k < NB; k++) begin
          if (old_bv[k]) begin
            if (hit_enemy[k]) m_bv[k] = 0;
            else if (frame) begin
              m_bt[k] = (m_bt[k] - 10 < 0) ? 0 : m_bt[k] - 10;
              if (m_bt[k] <= 10) m_bv[k] = 0;
            end
          end
        end
        free_k = -1;
        for (int k = NB - 1; k >= 0; k--) if (!old_bv[k]) free_k = k;
        if (rise && m_cd == 0 && free_k >= 0) begin
          m_bv[free_k] = 1; m_bt[free_k] = 424; m_bl[free_k] = old_pos + 20 - 3;
          m_cd = 4;
        end else if (frame && m_cd > 0) m_cd--;
        if (add_life && m_lives < 3) m_lives++;
      end
    end else if (old_st == ST_HIT_PAUSE) begin
      if (rise) begin m_pos = CENTER; m_st = btn; end
      if (add_life && m_lives < 3) m_lives++;
    end else begin
      if (rise) begin m_pos = CENTER; m_lives = 2; m_st = btn; end
    end
    m_prev = shoot;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]       st;
    logic [1:0]       lives;
    logic [9:0]       pos;
    logic [NB-1:0]    bv;
    logic [10*NB-1:0] bl;
    logic [10*NB-1:0] bt;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_expect();
    exp_t e;
    e.st = m_st; e.lives = 2'(m_lives); e.pos = 10'(m_pos);
    e.bv = '0; e.bl = '0; e.bt = '0;
    for (int k = 0; k < NB; k++) if (m_bv[k]) begin
      e.bv[k] = 1'b1;
      e.bl[10*k +: 10] = 10'(m_bl[k]);
      e.bt[10*k +: 10] = 10'(m_bt[k]);
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [10*NB-1:0] mask(input logic [10*NB-1:0] v, input logic [NB-1:0] m);
    for (int k = 0; k < NB; k++) if (!m[k]) v[10*k +: 10] = '0;
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", state, e.st);
        check("lives", lives, e.lives);
        check("pos_left", pos_left, e.pos);
        check("pos_right", pos_right, e.pos + 40);
        check("alive", alive, e.st != ST_DEAD);
        check("paused", paused, e.st == ST_HIT_PAUSE);
        check("bullet_valid", bvalid, e.bv);
        check("bullet_left", mask(bleft, bvalid), e.bl);
        check("bullet_top", mask(btop, bvalid), e.bt);
      end
    end
  end

  // ---------------- stimulus ----------------
  int  fcnt = 0;
  bit  last_frame;

  task automatic tick();
    @(posedge clk);
    last_frame = frame;
    model_step();
    push_expect();
    #1;
    fcnt  = (fcnt + 1) % 4;
    frame = (fcnt == 0);
  endtask

  task automatic run_frames(input int n);
    int seen = 0;
    for (int c = 0; c < 4 * n + 8 && seen < n; c++) begin
      tick();
      if (last_frame) seen++;
    end
  endtask

  task automatic pulse_shoot();
    shoot = 1'b1; tick();
    shoot = 1'b0; tick();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    model_reset();
    repeat (3) tick();
    check("reset_pos", pos_left, CENTER);
    check("red", red, 4'h5);
    check("green", green, 4'hE);
    check("blue", blue, 4'h5);
    rst_n = 1'b1;
    repeat (2) tick();

    // Left border clamp
    left = 1'b1; run_frames(60);
    check("left_border", pos_left, 9);
    check("left_border_right", pos_right, 49);
    left = 1'b0; tick();

    // Three staggered shots fill all slots; a fourth is dropped
    pulse_shoot(); run_frames(5);
    pulse_shoot(); run_frames(5);
    pulse_shoot();
    check("three_slots", bvalid, 3'b111);
    run_frames(5); pulse_shoot();
    check("full_drop", bvalid, 3'b111);
    run_frames(35); pulse_shoot();
    run_frames(45);

    // Cooldown blocks a second shot two frames later
    pulse_shoot(); run_frames(2); pulse_shoot();
    check("cooldown_block", $countones(bvalid), 1);
    run_frames(45);

    // Enemy hit retires slot 1, which is then reused
    pulse_shoot(); run_frames(5); pulse_shoot(); run_frames(2);
    hit_enemy = 3'b010; tick(); hit_enemy = '0;
    check("enemy_retire", bvalid[1], 1'b0);
    run_frames(3); pulse_shoot();
    check("slot_reuse", bvalid[1], 1'b1);

    // Ship hit with two lives, then resume
    hit = 1'b1; tick(); hit = 1'b0;
    check("hit_pause", paused, 1'b1);
    check("hit_lives", lives, 1);
    check("hit_clear", bvalid, 3'b000);
    run_frames(2); pulse_shoot();
    check("resume_state", state, ST_IDLE);
    check("resume_center", pos_left, CENTER);
    check("resume_nofire", bvalid, 3'b000);

    // Last life lost, bonus dropped while dead, new game
    hit = 1'b1; tick(); hit = 1'b0;
    check("dead_alive", alive, 1'b0);
    add_life = 1'b1; tick(); add_life = 1'b0;
    check("dead_no_bonus", lives, 0);
    pulse_shoot();
    check("new_game_state", state, ST_IDLE);
    check("new_game_lives", lives, 2);

    // Right border clamp and bonus saturation
    right = 1'b1; run_frames(70);
    check("right_border", pos_right, 629);
    right = 1'b0;
    repeat (3) begin add_life = 1'b1; tick(); add_life = 1'b0; tick(); end
    check("lives_saturate", lives, 3);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        left  = 1'($urandom_range(0, 1));
        right = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) shoot = ~shoot;
      hit       = ($urandom_range(0, 299) == 0);
      add_life  = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NB; k++) hit_enemy[k] = ($urandom_range(0, 15) == 0);
      tick();
    end
    left = 1'b0; right = 1'b0; shoot = 1'b0; hit = 1'b0; add_life = 1'b0; hit_enemy = '0;
    tick();

    // Asynchronous reset mid-flight
    pulse_shoot(); pulse_shoot(); run_frames(5); pulse_shoot(); run_frames(2);
    right = 1'b1; run_frames(3); right = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    check("areset_state", state, ST_IDLE);
    check("areset_pos", pos_left, CENTER);
    check("areset_lives", lives, 2);
    check("areset_valid", bvalid, 3'b000);
    check("areset_tops", btop, {10'd424, 10'd424, 10'd424});
    check("areset_alive", alive, 1'b1);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
